// File: rtl/toy_mext_iq_pkg.sv
// Shared types for the M-extension issue queue: EU payload, dispatch payload and opcode set.
package toy_mext_iq_pkg;

    localparam int REG_WIDTH    = 32;
    localparam int PHY_REG_ID_W = 6;

    typedef logic [PHY_REG_ID_W-1:0] phy_idx_t;

    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM,    OP_REMU
    } mext_op_e;

    typedef struct packed {
        mext_op_e             op;
        phy_idx_t             rd_idx;
        logic [7:0]           rob_id;
        logic [REG_WIDTH-1:0] reg_rs1_val;
        logic [REG_WIDTH-1:0] reg_rs2_val;
    } eu_pkg;

    typedef struct packed {
        eu_pkg    uop;
        phy_idx_t rs1_idx;
        phy_idx_t rs2_idx;
        logic     rs1_rdy;
        logic     rs2_rdy;
    } mext_iq_pkg;

endpackage

// File: rtl/toy_age_sel.sv
// Age matrix plus oldest-requester pick; older[j][i] set means entry j was allocated before entry i.
module toy_age_sel #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             alloc_en,
    input  logic [DEPTH-1:0] alloc_oh,
    input  logic [DEPTH-1:0] vld,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant
);

    logic [DEPTH-1:0][DEPTH-1:0] older;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older <= '0;
        end else if (clr) begin
            older <= '0;
        end else if (alloc_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        older[i][j] <= 1'b0;
                        older[j][i] <= vld[j] && (j != i);
                    end
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (req[j] && older[j][i]) blocked = 1'b1;
            end
            grant[i] = req[i] && !blocked;
        end
    end

endmodule

// File: rtl/toy_mext_iq.sv
// Issue queue for the M-ext EU: value-capture wakeup from writeback buses, oldest-ready issue.
module toy_mext_iq
    import toy_mext_iq_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int NUM_WB   = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     cancel_en,
    input  logic                                     disp_vld,
    output logic                                     disp_rdy,
    input  mext_iq_pkg                               disp_pld,
    input  logic [NUM_WB-1:0]                        wb_en,
    input  logic [NUM_WB-1:0][PHY_REG_ID_W-1:0]      wb_index,
    input  logic [NUM_WB-1:0][REG_WIDTH-1:0]         wb_val,
    output logic                                     instruction_vld,
    input  logic                                     instruction_rdy,
    output eu_pkg                                    instruction_pld,
    output logic [$clog2(IQ_DEPTH+1)-1:0]            iq_count
);

    localparam int CNT_W = $clog2(IQ_DEPTH + 1);
    localparam int IDX_W = $clog2(IQ_DEPTH);

    logic [IQ_DEPTH-1:0]  vld, rs1_ok, rs2_ok, rdy, alloc_oh, grant;
    eu_pkg                uop_q     [IQ_DEPTH];
    logic [REG_WIDTH-1:0] rs1_val_q [IQ_DEPTH];
    logic [REG_WIDTH-1:0] rs2_val_q [IQ_DEPTH];
    logic                 alloc, issue;
    logic [REG_WIDTH:0]   disp_wb1, disp_wb2;

    // Returns {hit, value}; the highest matching bus wins, though RAW makes all matches equal.
    function automatic logic [REG_WIDTH:0] wb_lookup(
        input phy_idx_t                              idx,
        input logic [NUM_WB-1:0]                     en,
        input logic [NUM_WB-1:0][PHY_REG_ID_W-1:0]   index,
        input logic [NUM_WB-1:0][REG_WIDTH-1:0]      val
    );
        wb_lookup = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (en[k] && index[k] == idx) wb_lookup = {1'b1, val[k]};
        end
    endfunction

    assign disp_rdy        = ~&vld;
    assign alloc           = disp_vld && disp_rdy && !cancel_en;
    assign rdy             = vld & rs1_ok & rs2_ok;
    assign instruction_vld = |rdy && !cancel_en;
    assign issue           = instruction_vld && instruction_rdy;
    assign disp_wb1        = wb_lookup(disp_pld.rs1_idx, wb_en, wb_index, wb_val);
    assign disp_wb2        = wb_lookup(disp_pld.rs2_idx, wb_en, wb_index, wb_val);

    always_comb begin
        alloc_oh = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (!vld[i]) alloc_oh = IQ_DEPTH'(1) << i;
        end
    end

    for (genvar g = 0; g < IQ_DEPTH; g++) begin : gen_entry
        logic                 e_vld, e_rs1_ok, e_rs2_ok, take;
        eu_pkg                e_uop;
        phy_idx_t             e_rs1_idx, e_rs2_idx;
        logic [REG_WIDTH-1:0] e_rs1_val, e_rs2_val;
        logic [REG_WIDTH:0]   wake1, wake2;

        assign take  = alloc && alloc_oh[g];
        assign wake1 = wb_lookup(e_rs1_idx, wb_en, wb_index, wb_val);
        assign wake2 = wb_lookup(e_rs2_idx, wb_en, wb_index, wb_val);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                e_vld    <= 1'b0;
                e_rs1_ok <= 1'b0;
                e_rs2_ok <= 1'b0;
            end else if (cancel_en) begin
                e_vld <= 1'b0;
            end else if (take) begin
                e_vld    <= 1'b1;
                e_rs1_ok <= disp_pld.rs1_rdy || disp_wb1[REG_WIDTH];
                e_rs2_ok <= disp_pld.rs2_rdy || disp_wb2[REG_WIDTH];
            end else begin
                if (issue && grant[g])                       e_vld    <= 1'b0;
                if (e_vld && !e_rs1_ok && wake1[REG_WIDTH])  e_rs1_ok <= 1'b1;
                if (e_vld && !e_rs2_ok && wake2[REG_WIDTH])  e_rs2_ok <= 1'b1;
            end
        end

        // NOTE: payload storage has no reset; it is only observed behind a set valid bit.
        always_ff @(posedge clk) begin
            if (take) begin
                e_uop     <= disp_pld.uop;
                e_rs1_idx <= disp_pld.rs1_idx;
                e_rs2_idx <= disp_pld.rs2_idx;
                e_rs1_val <= disp_pld.rs1_rdy ? disp_pld.uop.reg_rs1_val : disp_wb1[REG_WIDTH-1:0];
                e_rs2_val <= disp_pld.rs2_rdy ? disp_pld.uop.reg_rs2_val : disp_wb2[REG_WIDTH-1:0];
            end else begin
                if (!e_rs1_ok && wake1[REG_WIDTH]) e_rs1_val <= wake1[REG_WIDTH-1:0];
                if (!e_rs2_ok && wake2[REG_WIDTH]) e_rs2_val <= wake2[REG_WIDTH-1:0];
            end
        end

        assign vld[g]       = e_vld;
        assign rs1_ok[g]    = e_rs1_ok;
        assign rs2_ok[g]    = e_rs2_ok;
        assign uop_q[g]     = e_uop;
        assign rs1_val_q[g] = e_rs1_val;
        assign rs2_val_q[g] = e_rs2_val;
    end

    toy_age_sel #(.DEPTH(IQ_DEPTH)) u_age_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cancel_en),
        .alloc_en (alloc),
        .alloc_oh (alloc_oh),
        .vld      (vld),
        .req      (rdy),
        .grant    (grant)
    );

    // With no grant the mux falls back to entry 0.
    always_comb begin
        logic [IDX_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (grant[i]) sel = IDX_W'(i);
        end
        instruction_pld             = uop_q[sel];
        instruction_pld.reg_rs1_val = rs1_val_q[sel];
        instruction_pld.reg_rs2_val = rs2_val_q[sel];
    end

    always_comb begin
        iq_count = '0;
        for (int i = 0; i < IQ_DEPTH; i++) iq_count = iq_count + CNT_W'(vld[i]);
    end

endmodule
